// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: display scanline reads vs. logic writes, with
// vblank-selected priority and a bounded wait for the writer during active video.
module vram_arbiter #(
  parameter int AW         = 16,
  parameter int DW         = 8,
  parameter int RD_LAT     = 1,
  parameter int STARVE_MAX = 8
) (
  input  logic          clk_sys,
  input  logic          reset,
  input  logic          vblank,
  input  logic          disp_req,
  input  logic [AW-1:0] disp_addr,
  output logic          disp_gnt,
  output logic          disp_rvalid,
  output logic [DW-1:0] disp_rdata,
  input  logic          wr_valid,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  output logic          wr_ready,
  output logic [AW-1:0] ram_addr,
  output logic          ram_we,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata
);

  typedef enum logic [1:0] {
    DISP_PRI  = 2'd0,
    WR_PRI    = 2'd1,
    FORCED_WR = 2'd2
  } pri_state_t;

  localparam logic [7:0] STARVE_C = 8'(STARVE_MAX);

  pri_state_t  pri_state;
  logic [7:0]  starve_reg;
  logic [7:0]  starve_next;
  logic        rd_pipe_reg [RD_LAT+1];

  // Priority is a function of this cycle's vblank and the registered starve
  // count, so a vblank edge takes effect without a cycle of lag.
  always_comb begin
    pri_state = DISP_PRI;
    if (vblank) begin
      pri_state = WR_PRI;
    end else if (wr_valid && (starve_reg == STARVE_C)) begin
      pri_state = FORCED_WR;
    end
  end

  always_comb begin
    disp_gnt = 1'b0;
    wr_ready = 1'b0;
    if (!reset) begin
      case (pri_state)
        DISP_PRI: begin
          if (disp_req) begin
            disp_gnt = 1'b1;
          end else if (wr_valid) begin
            wr_ready = 1'b1;
          end
        end
        WR_PRI: begin
          if (wr_valid) begin
            wr_ready = 1'b1;
          end else if (disp_req) begin
            disp_gnt = 1'b1;
          end
        end
        FORCED_WR: begin
          wr_ready = 1'b1;
        end
        default: begin
          disp_gnt = 1'b0;
          wr_ready = 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    starve_next = starve_reg;
    if (!wr_valid || wr_ready) begin
      starve_next = 8'd0;
    end else if (disp_gnt && (starve_reg != STARVE_C)) begin
      starve_next = starve_reg + 8'd1;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      starve_reg <= 8'd0;
    end else begin
      starve_reg <= starve_next;
    end
  end

  // Address and write data hold on idle cycles; only the write enable drops.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      ram_addr  <= '0;
      ram_we    <= 1'b0;
      ram_wdata <= '0;
    end else begin
      ram_we <= wr_ready;
      if (wr_ready) begin
        ram_addr  <= wr_addr;
        ram_wdata <= wr_data;
      end else if (disp_gnt) begin
        ram_addr <= disp_addr;
      end
    end
  end

  // Read-valid tracker: stage k is high when the RAM address launched k
  // cycles ago was a display read; stage RD_LAT lines up with ram_rdata.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      rd_pipe_reg[0] <= 1'b0;
    end else begin
      rd_pipe_reg[0] <= disp_gnt;
    end
  end

  generate
    for (genvar gi = 1; gi <= RD_LAT; gi++) begin : g_rd_pipe
      always_ff @(posedge clk_sys) begin
        if (reset) begin
          rd_pipe_reg[gi] <= 1'b0;
        end else begin
          rd_pipe_reg[gi] <= rd_pipe_reg[gi-1];
        end
      end
    end
  endgenerate

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      disp_rvalid <= 1'b0;
      disp_rdata  <= '0;
    end else begin
      disp_rvalid <= rd_pipe_reg[RD_LAT];
      if (rd_pipe_reg[RD_LAT]) begin
        disp_rdata <= ram_rdata;
      end
    end
  end

endmodule

// File: tb/tb_vram_arbiter.sv
// Bench for vram_arbiter: directed scenarios then constrained-random traffic,
// each cycle compared against a rule-level model of grants, RAM port and reads.
module tb_vram_arbiter;
  localparam int AW         = 16;
  localparam int DW         = 8;
  localparam int RD_LAT     = 1;
  localparam int STARVE_MAX = 8;

  logic          clk_sys = 1'b0;
  logic          reset;
  logic          vblank;
  logic          disp_req;
  logic [AW-1:0] disp_addr;
  logic          disp_gnt;
  logic          disp_rvalid;
  logic [DW-1:0] disp_rdata;
  logic          wr_valid;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          wr_ready;
  logic [AW-1:0] ram_addr;
  logic          ram_we;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;

  always #5 clk_sys = ~clk_sys;

  vram_arbiter #(
    .AW(AW), .DW(DW), .RD_LAT(RD_LAT), .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clk_sys(clk_sys), .reset(reset), .vblank(vblank),
    .disp_req(disp_req), .disp_addr(disp_addr), .disp_gnt(disp_gnt),
    .disp_rvalid(disp_rvalid), .disp_rdata(disp_rdata),
    .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  // RAM stand-in with one cycle of read latency; contents are addr[7:0].
  always @(posedge clk_sys) ram_rdata <= ram_addr[7:0];

  typedef struct {
    int            due;
    logic [DW-1:0] data;
  } rd_t;

  rd_t           rq[$];
  int            total = 0;
  int            bad = 0;
  int            cyc = 0;
  int            streak = 0;
  logic [AW-1:0] e_addr;
  logic          e_we;
  logic [DW-1:0] e_wdata;
  bit            regs_known = 0;
  bit            last_dg = 0;
  bit            last_wg = 0;
  int            run = 0;
  int            max_run = 0;
  int            wr_cnt = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, obs, exp);
    end
  endtask

  // One clock cycle: predict, compare at the falling edge, advance the model.
  task automatic step();
    bit            dg;
    bit            wg;
    bit            rv;
    logic [DW-1:0] rd;
    @(negedge clk_sys);
    dg = 0;
    wg = 0;
    if (!reset) begin
      if (vblank) begin
        if (wr_valid) wg = 1;
        else if (disp_req) dg = 1;
      end else if (wr_valid && streak >= STARVE_MAX) begin
        wg = 1;
      end else if (disp_req) begin
        dg = 1;
      end else if (wr_valid) begin
        wg = 1;
      end
    end
    check("disp_gnt", 32'(disp_gnt), 32'(dg));
    check("wr_ready", 32'(wr_ready), 32'(wg));
    rv = 0;
    rd = '0;
    if (rq.size() > 0 && rq[0].due == cyc) begin
      rv = 1;
      rd = rq[0].data;
      void'(rq.pop_front());
    end
    if (regs_known) begin
      check("ram_we", 32'(ram_we), 32'(e_we));
      check("ram_addr", 32'(ram_addr), 32'(e_addr));
      check("ram_wdata", 32'(ram_wdata), 32'(e_wdata));
      check("disp_rvalid", 32'(disp_rvalid), 32'(rv));
      if (rv) check("disp_rdata", 32'(disp_rdata), 32'(rd));
    end
    if (disp_gnt) begin
      run++;
      if (run > max_run) max_run = run;
    end else begin
      run = 0;
    end
    if (wr_ready) wr_cnt++;
    if (reset) begin
      e_addr = '0;
      e_we = 0;
      e_wdata = '0;
      rq.delete();
      streak = 0;
      regs_known = 1;
    end else begin
      e_we = wg;
      if (wg) begin
        e_addr = wr_addr;
        e_wdata = wr_data;
      end else if (dg) begin
        e_addr = disp_addr;
        rq.push_back('{cyc + 1 + RD_LAT + 1, disp_addr[7:0]});
      end
      if (wr_valid && dg) streak = (streak < STARVE_MAX) ? streak + 1 : STARVE_MAX;
      else if (!wr_valid || wg) streak = 0;
    end
    last_dg = dg;
    last_wg = wg;
    @(posedge clk_sys);
    #1;
    cyc++;
  endtask

  initial begin
    reset = 1; vblank = 0;
    disp_req = 1; disp_addr = 16'h0001;
    wr_valid = 1; wr_addr = 16'h0002; wr_data = 8'h03;
    @(posedge clk_sys);
    #1;
    regs_known = 1; e_addr = '0; e_we = 0; e_wdata = '0;

    // Reset held with both requesters active
    repeat (3) step();
    reset = 0; disp_req = 0; wr_valid = 0;
    repeat (2) step();

    // Single display read
    disp_req = 1; disp_addr = 16'h0123;
    step();
    disp_req = 0;
    repeat (4) step();

    // Single write, no display traffic
    wr_valid = 1; wr_addr = 16'h0040; wr_data = 8'hA5;
    step();
    wr_valid = 0;
    repeat (2) step();

    // Starvation guard during active video
    disp_req = 1; disp_addr = 16'h0BEE;
    wr_valid = 1; wr_addr = 16'h1234; wr_data = 8'h5A;
    run = 0; max_run = 0; wr_cnt = 0;
    repeat (27) step();
    check("t4_max_disp_run", 32'(max_run), 32'(STARVE_MAX));
    check("t4_forced_writes", 32'(wr_cnt), 32'd3);

    // vblank gives the writer every cycle; display resumes on the vblank drop
    vblank = 1; wr_cnt = 0; run = 0;
    repeat (6) step();
    check("t5_vblank_writes", 32'(wr_cnt), 32'd6);
    vblank = 0;
    step();
    check("t5_disp_resume", 32'(run), 32'd1);
    disp_req = 0; wr_valid = 0;
    repeat (4) step();

    // Reset one cycle after a read grant discards the return
    disp_req = 1; disp_addr = 16'h0456;
    step();
    disp_req = 0; reset = 1;
    step();
    reset = 0;
    repeat (4) step();
    disp_req = 1; disp_addr = 16'h0789;
    step();
    disp_req = 0;
    repeat (4) step();

    // Constrained-random traffic honouring the hold-until-accepted rules
    for (int i = 0; i < 800; i++) begin
      if (!disp_req || last_dg) begin
        disp_req = ($urandom_range(0, 99) < 60);
        disp_addr = AW'($urandom);
      end
      if (!wr_valid || last_wg) begin
        wr_valid = ($urandom_range(0, 99) < 50);
        wr_addr = AW'($urandom);
        wr_data = DW'($urandom);
      end
      if ($urandom_range(0, 39) == 0) vblank = ~vblank;
      reset = ($urandom_range(0, 199) == 0);
      step();
    end
    reset = 0; disp_req = 0; wr_valid = 0;
    repeat (5) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
